// File: rtl/nibble_serial_comparator.sv
// nibble_serial_comparator
// Sequential unsigned magnitude comparator for two WIDTH-bit operands.
// One 4-bit nibble is compared per clock, least significant nibble first,
// with the lt/eq/gt cascade state held in registers and fed back each cycle.
// Because later (more significant) nibbles override earlier decisions, the
// final cascade value is the magnitude order of the full operands.
//
// Optional feature macro: CASCADE_IN_EN
//   When defined, adds lt_in/eq_in/gt_in. They are sampled on the accept edge
//   as the initial cascade state, so several blocks can be chained for
//   operands wider than WIDTH. When undefined, the initial state is 010.
//
// Handshake rules (both ports): a transfer happens on a rising clock edge
// where valid && ready are both high. The producer holds a/b stable with
// in_valid until accepted. Once out_valid rises, the result is held until
// out_ready is seen high. in_ready is high only in IDLE, so a new pair is
// never accepted while a result is pending.
//
// state_dbg exposes the FSM state (0=IDLE, 1=RUN, 2=DONE) for observation.

module nibble_serial_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CASCADE_IN_EN
  input  logic             lt_in,
  input  logic             eq_in,
  input  logic             gt_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic [1:0]       state_dbg
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [IDXW-1:0]  idx;
  logic [2:0]       casc;       // {lt, eq, gt}
  logic [2:0]       casc_next;
  logic [2:0]       casc_init;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;

  assign state_dbg = state;

  // The current nibble is always the low nibble of the shift registers.
  assign a_nib = a_sh[3:0];
  assign b_nib = b_sh[3:0];

`ifdef CASCADE_IN_EN
  assign casc_init = {lt_in, eq_in, gt_in};
`else
  assign casc_init = 3'b010;
`endif

  // Cascade update for one nibble: a difference decides, equality passes
  // the less significant decision through unchanged.
  always_comb begin
    casc_next = casc;
    if (a_nib > b_nib) begin
      casc_next = 3'b001;
    end else if (a_nib < b_nib) begin
      casc_next = 3'b100;
    end
  end

  // Control FSM with registered handshake signals and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_lt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      a_gt_b    <= 1'b0;
      idx       <= '0;
      casc      <= 3'b000;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            casc     <= casc_init;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          casc <= casc_next;
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          if (idx == LAST_IDX) begin
            // Final nibble: publish the result in the same edge so the
            // flags and out_valid rise together.
            out_valid <= 1'b1;
            a_lt_b    <= casc_next[2];
            a_eq_b    <= casc_next[1];
            a_gt_b    <= casc_next[0];
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            a_lt_b    <= 1'b0;
            a_eq_b    <= 1'b0;
            a_gt_b    <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          a_lt_b    <= 1'b0;
          a_eq_b    <= 1'b0;
          a_gt_b    <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Directed testbench for nibble_serial_comparator (WIDTH=16).
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, away from the active rising edge.

module tb_nibble_serial_comparator;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef CASCADE_IN_EN
  logic             lt_in;
  logic             eq_in;
  logic             gt_in;
`endif
  logic             out_valid;
  logic             out_ready;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             a_gt_b;
  logic [1:0]       state_dbg;

  int errors = 0;
  int checks = 0;

  nibble_serial_comparator #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef CASCADE_IN_EN
    .lt_in     (lt_in),
    .eq_in     (eq_in),
    .gt_in     (gt_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_lt_b    (a_lt_b),
    .a_eq_b    (a_eq_b),
    .a_gt_b    (a_gt_b),
    .state_dbg (state_dbg)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {a_lt_b, a_eq_b, a_gt_b};
  endfunction

  // Present a pair in IDLE and let it be accepted on the next rising edge.
  // Returns at the falling edge just after the accept edge.
  task automatic start_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    check({tag, ".ready_before"}, in_ready, 1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    check({tag, ".ready_drop"}, in_ready, 0);
    check({tag, ".state_run"}, state_dbg, 1);
  endtask

  // Wait (bounded) for out_valid and check latency and flags.
  task automatic wait_result(input string tag, input logic [2:0] exp_flags);
    int cycles;
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    // first falling edge after accept precedes E1; out_valid appears after E4
    check({tag, ".latency"}, cycles - 1, 4);
    check({tag, ".flags"}, flags(), exp_flags);
  endtask

  // Assumes out_ready=1: handshake on the next edge, then back in IDLE.
  task automatic end_op(input string tag);
    @(negedge clk);
    check({tag, ".valid_drop"}, out_valid, 0);
    check({tag, ".ready_back"}, in_ready, 1);
  endtask

  task automatic full_op(input string tag, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic [2:0] exp_flags);
    start_op(tag, av, bv);
    wait_result(tag, exp_flags);
    end_op(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
`ifdef CASCADE_IN_EN
    lt_in = 1'b0;
    eq_in = 1'b1;
    gt_in = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.flags", flags(), 3'b000);
    check("rst.state", state_dbg, 0);
    rst_n = 1'b1;

    // Basic operation and ordering cases
    full_op("eq_1234", 16'h1234, 16'h1234, 3'b010);
    full_op("msb_override", 16'h8000, 16'h7FFF, 3'b001);
    full_op("lt_small", 16'h0001, 16'h0002, 3'b100);
    full_op("gt_max", 16'hFFFF, 16'h0000, 3'b001);
    full_op("eq_zero", 16'h0000, 16'h0000, 3'b010);
    full_op("lt_max", 16'hFFFE, 16'hFFFF, 3'b100);

    // Backpressure: result held, in_valid ignored in DONE
    out_ready = 1'b0;
    start_op("bp", 16'h0010, 16'h0001);
    wait_result("bp", 3'b001);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a        = '0;
        b        = '0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp.hold_valid", out_valid, 1);
      check("bp.hold_flags", flags(), 3'b001);
      check("bp.hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    end_op("bp");

    // Asynchronous reset after two RUN cycles
    start_op("rst_mid", 16'h1111, 16'h2222);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.in_ready", in_ready, 1);
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.flags", flags(), 3'b000);
    check("rst_mid.state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    full_op("after_rst", 16'h00FF, 16'h0100, 3'b100);

`ifdef CASCADE_IN_EN
    lt_in = 1'b0; eq_in = 1'b0; gt_in = 1'b1;
    full_op("casc_gt_in", 16'hABCD, 16'hABCD, 3'b001);
    lt_in = 1'b1; eq_in = 1'b0; gt_in = 1'b0;
    full_op("casc_override", 16'hABCE, 16'hABCD, 3'b001);
    lt_in = 1'b1; eq_in = 1'b0; gt_in = 1'b1;
    full_op("casc_verbatim", 16'h5A5A, 16'h5A5A, 3'b101);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
